// File: rtl/ptp_ts_queue.sv
// Multi-channel PTP timestamp queue: per-channel hold slots, round-robin
// arbitration into a DEPTH-entry show-ahead FIFO, a level interrupt and a
// saturating drop counter. Single clock domain (rtc_clk).
module ptp_ts_queue #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned TS_W   = 96,
   parameter int unsigned META_W = 24,
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                     rtc_clk,
   input  logic                     rtc_rst,
   input  logic                     enable_i,
   input  logic                     flush_i,
   input  logic [NUM_CH-1:0]        cap_vld_i,
   input  logic [NUM_CH*TS_W-1:0]   cap_ts_i,
   input  logic [NUM_CH*META_W-1:0] cap_meta_i,
   input  logic                     pop_i,
   output logic                     rd_vld_o,
   output logic [CH_W-1:0]          rd_ch_o,
   output logic [TS_W-1:0]          rd_ts_o,
   output logic [META_W-1:0]        rd_meta_o,
   output logic [AW:0]              level_o,
   input  logic [AW:0]              int_thresh_i,
   output logic                     int_o,
   input  logic                     ovf_clr_i,
   output logic [15:0]              ovf_cnt_o
);

   localparam int unsigned DW     = $clog2(NUM_CH + 1);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   // Hold slots
   logic [NUM_CH-1:0]              hold_vld_q, hold_vld_d;
   logic [NUM_CH-1:0][TS_W-1:0]    hold_ts_q;
   logic [NUM_CH-1:0][META_W-1:0]  hold_meta_q;
   logic [NUM_CH-1:0]              load_v;

   // Arbiter
   logic [CH_W-1:0]                rr_ptr_q, rr_ptr_d;
   logic                           gnt_vld;
   logic [CH_W-1:0]                gnt_ch;

   // FIFO
   logic [CH_W-1:0]                mem_ch_q   [DEPTH];
   logic [TS_W-1:0]                mem_ts_q   [DEPTH];
   logic [META_W-1:0]              mem_meta_q [DEPTH];
   logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]                  rd_ptr_q, rd_ptr_d;
   logic [AW:0]                    level_q, level_d;
   logic                           push, pop;

   // Status
   logic                           int_q, int_d;
   logic [15:0]                    ovf_q, ovf_d;
   logic [DW-1:0]                  drop_cnt;
   logic [16:0]                    ovf_sum;

   function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base,
                                              input int unsigned off);
      rr_idx = CH_W'((32'(base) + off) % NUM_CH);
   endfunction

   // Round-robin pick among valid slots, gated by FIFO write room
   always_comb begin
      logic wr_allow;
      gnt_vld  = 1'b0;
      gnt_ch   = '0;
      wr_allow = (level_q != LVL_FULL) || (pop_i && (level_q != '0));
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!gnt_vld && wr_allow && hold_vld_q[rr_idx(rr_ptr_q, i)]) begin
            gnt_vld = 1'b1;
            gnt_ch  = rr_idx(rr_ptr_q, i);
         end
      end
   end

   // Next state for slots, pointers, level, interrupt and drop counter
   always_comb begin
      hold_vld_d = hold_vld_q;
      load_v     = '0;
      drop_cnt   = '0;
      rr_ptr_d   = rr_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      push       = 1'b0;
      pop        = 1'b0;
      ovf_sum    = '0;
      ovf_d      = ovf_q;
      int_d      = (int_thresh_i != '0) && (level_q >= int_thresh_i);

      if (flush_i) begin
         hold_vld_d = '0;
         rr_ptr_d   = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
      end else begin
         push = gnt_vld;
         pop  = pop_i && (level_q != '0);
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            logic granted;
            granted = gnt_vld && (gnt_ch == CH_W'(c));
            if (granted) begin
               hold_vld_d[c] = 1'b0;
            end
            if (cap_vld_i[c] && enable_i) begin
               if (!hold_vld_q[c] || granted) begin
                  hold_vld_d[c] = 1'b1;
                  load_v[c]     = 1'b1;
               end else begin
                  drop_cnt = drop_cnt + DW'(1);
               end
            end
         end
         if (gnt_vld) begin
            rr_ptr_d = rr_idx(gnt_ch, 1);
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
         endcase
      end

      ovf_sum = 17'(ovf_q) + 17'(drop_cnt);
      if (ovf_clr_i) begin
         ovf_d = 16'(drop_cnt);
      end else if (ovf_sum[16]) begin
         ovf_d = 16'hFFFF;
      end else begin
         ovf_d = ovf_sum[15:0];
      end
   end

   // Control state registers
   always_ff @(posedge rtc_clk or posedge rtc_rst) begin
      if (rtc_rst) begin
         hold_vld_q <= '0;
         rr_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         int_q      <= 1'b0;
         ovf_q      <= '0;
      end else begin
         hold_vld_q <= hold_vld_d;
         rr_ptr_q   <= rr_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         int_q      <= int_d;
         ovf_q      <= ovf_d;
      end
   end

   // Hold slot payload capture (qualified by the slot valid bit)
   always_ff @(posedge rtc_clk) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (load_v[c]) begin
            hold_ts_q[c]   <= cap_ts_i[c*TS_W +: TS_W];
            hold_meta_q[c] <= cap_meta_i[c*META_W +: META_W];
         end
      end
   end

   // FIFO storage write of the granted record
   always_ff @(posedge rtc_clk) begin
      if (push) begin
         mem_ch_q[wr_ptr_q]   <= gnt_ch;
         mem_ts_q[wr_ptr_q]   <= hold_ts_q[gnt_ch];
         mem_meta_q[wr_ptr_q] <= hold_meta_q[gnt_ch];
      end
   end

   // Show-ahead head; forced to zero when empty so reset values are defined
   always_comb begin
      rd_vld_o  = (level_q != '0);
      rd_ch_o   = '0;
      rd_ts_o   = '0;
      rd_meta_o = '0;
      if (rd_vld_o) begin
         rd_ch_o   = mem_ch_q[rd_ptr_q];
         rd_ts_o   = mem_ts_q[rd_ptr_q];
         rd_meta_o = mem_meta_q[rd_ptr_q];
      end
   end

   assign level_o   = level_q;
   assign int_o     = int_q;
   assign ovf_cnt_o = ovf_q;

endmodule

// File: tb/tb_ptp_ts_queue.sv
// Directed bench for ptp_ts_queue (NUM_CH=2, DEPTH=4).
module tb_ptp_ts_queue;

   localparam int unsigned NUM_CH = 2;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned TS_W   = 96;
   localparam int unsigned META_W = 24;
   localparam int unsigned CH_W   = 1;
   localparam int unsigned AW     = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     enable;
   logic                     flush;
   logic [NUM_CH-1:0]        cap_vld;
   logic [NUM_CH*TS_W-1:0]   cap_ts;
   logic [NUM_CH*META_W-1:0] cap_meta;
   logic                     pop;
   logic                     rd_vld;
   logic [CH_W-1:0]          rd_ch;
   logic [TS_W-1:0]          rd_ts;
   logic [META_W-1:0]        rd_meta;
   logic [AW:0]              level;
   logic [AW:0]              thresh;
   logic                     irq;
   logic                     ovf_clr;
   logic [15:0]              ovf_cnt;

   int checks   = 0;
   int failures = 0;

   ptp_ts_queue #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TS_W(TS_W), .META_W(META_W)) dut (
      .rtc_clk      (clk),
      .rtc_rst      (rst),
      .enable_i     (enable),
      .flush_i      (flush),
      .cap_vld_i    (cap_vld),
      .cap_ts_i     (cap_ts),
      .cap_meta_i   (cap_meta),
      .pop_i        (pop),
      .rd_vld_o     (rd_vld),
      .rd_ch_o      (rd_ch),
      .rd_ts_o      (rd_ts),
      .rd_meta_o    (rd_meta),
      .level_o      (level),
      .int_thresh_i (thresh),
      .int_o        (irq),
      .ovf_clr_i    (ovf_clr),
      .ovf_cnt_o    (ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cap(input int unsigned c, input logic [TS_W-1:0] ts, input logic [META_W-1:0] meta);
      cap_vld[c]                 = 1'b1;
      cap_ts[c*TS_W +: TS_W]     = ts;
      cap_meta[c*META_W +: META_W] = meta;
   endtask

   initial begin
      logic [TS_W-1:0] exp_ts;
      logic            exp_ch;

      rst      = 1'b1;
      enable   = 1'b1;
      flush    = 1'b0;
      cap_vld  = '0;
      cap_ts   = '0;
      cap_meta = '0;
      pop      = 1'b0;
      thresh   = '0;
      ovf_clr  = 1'b0;
      #12;
      rst = 1'b0;
      #1;
      chk("rst_rd_vld", 128'(rd_vld), 128'(0));
      chk("rst_level",  128'(level),  128'(0));
      chk("rst_int",    128'(irq),    128'(0));
      chk("rst_ovf",    128'(ovf_cnt), 128'(0));
      chk("rst_rd_ts",  128'(rd_ts),  128'(0));

      // Single capture on ch1
      set_cap(1, 96'h1234, 24'h00A5B1);
      tick();
      cap_vld = '0;
      chk("single_lvl_e0", 128'(level), 128'(0));
      tick();
      chk("single_vld",  128'(rd_vld),  128'(1));
      chk("single_lvl",  128'(level),   128'(1));
      chk("single_ch",   128'(rd_ch),   128'(1));
      chk("single_ts",   128'(rd_ts),   128'(96'h1234));
      chk("single_meta", 128'(rd_meta), 128'(24'h00A5B1));
      pop = 1'b1;
      tick();
      pop = 1'b0;
      chk("single_pop_lvl", 128'(level),  128'(0));
      chk("single_pop_vld", 128'(rd_vld), 128'(0));

      // Fairness: three simultaneous pairs, 4 cycles apart; third pair meets a full FIFO
      for (int k = 0; k < 3; k++) begin
         set_cap(0, 96'(16*k + 0), 24'(k));
         set_cap(1, 96'(16*k + 1), 24'(k));
         tick();
         cap_vld = '0;
         tick(); tick(); tick();
      end
      chk("fair_full_lvl", 128'(level), 128'(4));
      for (int n = 0; n < 6; n++) begin
         exp_ch = 1'(n % 2);
         exp_ts = 96'(16*(n/2) + (n % 2));
         chk($sformatf("fair_ch%0d", n), 128'(rd_ch), 128'(exp_ch));
         chk($sformatf("fair_ts%0d", n), 128'(rd_ts), 128'(exp_ts));
         if (n < 2) chk($sformatf("fair_lvl%0d", n), 128'(level), 128'(4));
         pop = 1'b1;
         tick();
         pop = 1'b0;
      end
      chk("fair_empty", 128'(level), 128'(0));
      chk("fair_ovf",   128'(ovf_cnt), 128'(0));

      // Overflow: seven strobes on ch0 with no pops
      for (int i = 0; i < 7; i++) begin
         set_cap(0, 96'(32'h100 + i), 24'(i));
         tick();
      end
      cap_vld = '0;
      chk("ovf_lvl", 128'(level),   128'(4));
      chk("ovf_cnt", 128'(ovf_cnt), 128'(2));
      chk("ovf_head", 128'(rd_ts),  128'(96'h100));

      // Full with concurrent pop: held record enters, head advances
      pop = 1'b1;
      tick();
      pop = 1'b0;
      chk("fullpop_lvl",  128'(level), 128'(4));
      chk("fullpop_head", 128'(rd_ts), 128'(96'h101));
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("ovf_drain%0d", i), 128'(rd_ts), 128'(96'(32'h100 + i)));
         pop = 1'b1;
         tick();
         pop = 1'b0;
      end
      chk("ovf_drain_lvl", 128'(level),  128'(0));
      chk("ovf_drain_vld", 128'(rd_vld), 128'(0));

      // Interrupt threshold then flush with a same-cycle strobe
      thresh = 3'(3);
      for (int i = 0; i < 3; i++) begin
         set_cap(0, 96'(32'h200 + i), 24'(i));
         tick();
      end
      cap_vld = '0;
      chk("irq_lvl2", 128'(level), 128'(2));
      tick();
      chk("irq_lvl3", 128'(level), 128'(3));
      chk("irq_lag",  128'(irq),   128'(0));
      tick();
      chk("irq_set",  128'(irq),   128'(1));
      flush = 1'b1;
      set_cap(0, 96'h999, 24'h9);
      set_cap(1, 96'h998, 24'h8);
      tick();
      flush   = 1'b0;
      cap_vld = '0;
      chk("flush_lvl", 128'(level),   128'(0));
      chk("flush_vld", 128'(rd_vld),  128'(0));
      chk("flush_ovf", 128'(ovf_cnt), 128'(2));
      tick();
      chk("flush_irq", 128'(irq),     128'(0));
      tick();
      chk("flush_discard", 128'(level), 128'(0));
      thresh = '0;

      // Counter: fill FIFO and both slots, then drop 2 per cycle
      for (int i = 0; i < 5; i++) begin
         set_cap(0, 96'(32'h300 + i), 24'(i));
         tick();
      end
      cap_vld = '0;
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("cnt_clr", 128'(ovf_cnt), 128'(0));
      set_cap(1, 96'h3FF, 24'h1);
      tick();
      chk("cnt_slot1_nodrop", 128'(ovf_cnt), 128'(0));
      cap_vld = 2'b11;
      tick();
      chk("cnt_two", 128'(ovf_cnt), 128'(2));
      for (int i = 0; i < 32766; i++) tick();
      chk("cnt_fffe", 128'(ovf_cnt), 128'(16'hFFFE));
      tick();
      chk("cnt_sat",  128'(ovf_cnt), 128'(16'hFFFF));
      tick();
      chk("cnt_hold", 128'(ovf_cnt), 128'(16'hFFFF));
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("cnt_clr_drops", 128'(ovf_cnt), 128'(2));
      chk("cnt_lvl_full",  128'(level),   128'(4));

      // Async reset mid-stream
      #2;
      rst = 1'b1;
      #1;
      chk("arst_lvl", 128'(level),   128'(0));
      chk("arst_vld", 128'(rd_vld),  128'(0));
      chk("arst_ovf", 128'(ovf_cnt), 128'(0));
      chk("arst_irq", 128'(irq),     128'(0));
      chk("arst_ts",  128'(rd_ts),   128'(0));
      chk("arst_ch",  128'(rd_ch),   128'(0));
      cap_vld = '0;
      #1;
      rst = 1'b0;
      tick();
      chk("arst_post_lvl", 128'(level), 128'(0));
      set_cap(1, 96'hABCD, 24'h7);
      tick();
      cap_vld = '0;
      tick();
      chk("arst_resume_lvl", 128'(level), 128'(1));
      chk("arst_resume_ch",  128'(rd_ch), 128'(1));
      chk("arst_resume_ts",  128'(rd_ts), 128'(96'hABCD));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
